spike_network: RTL
==================

// Module: spike_network
// PURPOSE
//  Inter-neuron spike arbiter between the neuron array and its spike_in bus.
//  Consumes every neuron's 2-bit spike_out and selects at most one spike per
//  network phase, using round-robin priority. It drives the shared
//  {ten, neuron_id} word back to all neurons and pulses networkDone.
//  The handshake is en_network from the neurons: the AND of all neuron
//  en_network outputs, formed outside this block.
// PARAMETERS
//  NUM_NEURON       512  number of spike lanes in spike_vec
//  NEURON_ID_WIDTH  9    width of neuron index / active_neuron
//  TEN_DATA_WIDTH   2    spike code width (0=none, 1=positive, 2=negative, 3=illegal)
//  CNT_WIDTH        16   width of spike_count
// PORTS
//  clk            in   1                             single clock, rising edge
//  reset          in   1                             async, active-high; clears all state
//  en_network     in   1                             request from neuron array, level
//  active_neuron  in   NEURON_ID_WIDTH               lanes 0..active_neuron-1 are scanned
//  spike_vec      in   TEN_DATA_WIDTH*NUM_NEURON     lane i = bits [2i+1:2i]
//  spike_in       out  TEN_DATA_WIDTH+NEURON_ID_WIDTH {ten, id} broadcast to neurons
//  networkDone    out  1                             one-cycle completion pulse
//  spike_count    out  CNT_WIDTH                     nonzero spikes issued, saturating
//  err_illegal    out  1                             sticky; lane with code 3 was scanned
// BEHAVIOUR
//  Reset: all outputs are 0, rr_ptr=0, state=IDLE. Reset takes effect immediately,
//   including mid-scan; no networkDone is issued for an aborted phase.
//  States:
//   IDLE:    if en_network=1 -> SCAN with idx=rr_ptr, cnt=0.
//   SCAN:    examines lane idx once per cycle.
//    - code 1/2: latch spike_in={code,idx}; rr_ptr=(idx+1) wrap at N -> DONE.
//    - code 0 or 3: idx=idx+1, wrap to 0 at idx=N-1; cnt=cnt+1.
//      Code 3 also sets err_illegal and is never issued.
//    - no spike after N lanes (cnt=N-1 and still no spike): latch spike_in=0, rr_ptr
//      unchanged -> DONE.
//    - en_network=0 at any SCAN cycle: abort -> IDLE; spike_in and rr_ptr unchanged.
//   DONE:    networkDone=1 for exactly this cycle -> RELEASE.
//   RELEASE: wait for en_network=0, then -> IDLE. This blocks re-triggering on a
//    stale request.
//  Effective count N = min(active_neuron, NUM_NEURON), with rr_ptr clamped to < N.
//   active_neuron=0: one SCAN cycle, no lane read, spike_in=0, then DONE.
//   active_neuron changing mid-scan: sampled only on IDLE->SCAN.
//  Latency: let en_network be sampled high in IDLE at cycle 0, and the hit be at
//   offset k from rr_ptr. Then networkDone is high in cycle k+2. Worst case (no
//   spike) networkDone is high in cycle N+1.
//  spike_in is registered. It holds its value from DONE until the next hit or
//   empty result, so neurons may sample it in any later cycle (RECV1).
//  spike_count increments by 1 in the DONE cycle when the issued code is nonzero,
//   and saturates at all-ones.
//  spike_vec must be stable during SCAN. The block does not snapshot it.
//  Index arithmetic is unsigned, NEURON_ID_WIDTH bits, with explicit wrap compare
//   (never modulo).
// TESTING
//  1 Reset, N=8, lane 5=2'b01, others 0, raise en_network -> networkDone in cycle 7,
//    spike_in={2'b01,9'd5}, spike_count=1.
//  2 Lanes 2 and 6 = 2'b10, three back-to-back phases (en_network dropped between)
//    -> ids 2, 6, 2 (round-robin wrap); rr_ptr=3 after the third phase.
//  3 N=8, all lanes 0 -> networkDone in cycle 9, spike_in=0, spike_count unchanged,
//    rr_ptr unchanged.
//  4 Lane 1=2'b11, lane 4=2'b01 -> lane 1 skipped, err_illegal=1 (sticky),
//    spike_in={01,4}.
//  5 Drop en_network at cycle 3 of a scan -> no networkDone, state IDLE; then assert
//    reset mid-scan -> all outputs 0 immediately.
//  6 active_neuron=0 -> networkDone in cycle 2, spike_in=0; hold en_network high after
//    DONE -> no second pulse until it has gone low and high again.

Source files
------------

// File: rtl/spike_network_if.sv
// Spike network bus: the neuron-array side drives the request, the scan
// range and the spike lanes. The arbiter drives back the broadcast spike
// word, the completion pulse, the counters and the debug view of its FSM.
//
// Handshake: en_network is a level request. The arbiter answers each
// accepted request with one networkDone pulse. It then waits for
// en_network to go low before it will accept the next request.
interface spike_network_if #(
   parameter int NUM_NEURON      = 512,
   parameter int NEURON_ID_WIDTH = 9,
   parameter int TEN_DATA_WIDTH  = 2,
   parameter int CNT_WIDTH       = 16
);
   logic                                     en_network;
   logic [NEURON_ID_WIDTH-1:0]               active_neuron;
   logic [TEN_DATA_WIDTH*NUM_NEURON-1:0]     spike_vec;
   logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in;
   logic                                     networkDone;
   logic [CNT_WIDTH-1:0]                     spike_count;
   logic                                     err_illegal;
   logic [1:0]                               dbg_state;
   logic [NEURON_ID_WIDTH-1:0]               dbg_rr_ptr;

   modport master (
      output en_network, active_neuron, spike_vec,
      input  spike_in, networkDone, spike_count, err_illegal, dbg_state, dbg_rr_ptr
   );

   modport slave (
      input  en_network, active_neuron, spike_vec,
      output spike_in, networkDone, spike_count, err_illegal, dbg_state, dbg_rr_ptr
   );
endinterface

// File: rtl/spike_network.sv
// Round-robin spike arbiter. Each network phase scans the active lanes,
// starting at the round-robin pointer and checking one lane per cycle.
// It issues the first positive or negative spike it finds as {ten, id}.
// If no lane holds a spike, it issues a zero word.
module spike_network #(
   parameter int NUM_NEURON      = 512,
   parameter int NEURON_ID_WIDTH = 9,
   parameter int TEN_DATA_WIDTH  = 2,
   parameter int CNT_WIDTH       = 16
) (
   input  logic            clk,
   input  logic            reset,
   spike_network_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SCAN    = 2'd1,
      S_DONE    = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   // Lane counts are one bit wider than an id, so that N itself is representable.
   localparam int NW = NEURON_ID_WIDTH + 1;
   localparam logic [NW-1:0] LP_NUM = (NUM_NEURON >= (1 << NW)) ? {NW{1'b1}} : NW'(NUM_NEURON);
   localparam int SW = TEN_DATA_WIDTH + NEURON_ID_WIDTH;

   state_t                     r_state,       w_state_nxt;
   logic [NEURON_ID_WIDTH-1:0] r_idx,         w_idx_nxt;
   logic [NW-1:0]              r_cnt,         w_cnt_nxt;
   logic [NW-1:0]              r_n,           w_n_nxt;
   logic [NEURON_ID_WIDTH-1:0] r_rr_ptr,      w_rr_ptr_nxt;
   logic [SW-1:0]              r_spike_in,    w_spike_in_nxt;
   logic [CNT_WIDTH-1:0]       r_spike_count, w_spike_count_nxt;
   logic                       r_err,         w_err_nxt;

   logic [NW-1:0]              w_active_ext;
   logic [NW-1:0]              w_n_sel;
   logic [NEURON_ID_WIDTH-1:0] w_start_idx;
   logic [TEN_DATA_WIDTH-1:0]  w_lane;
   logic [NW-1:0]              w_n_last;
   logic                       w_last_lane;
   logic [NEURON_ID_WIDTH-1:0] w_idx_inc;

   // Scan geometry: the effective lane count, the clamped start point, the
   // current lane code and the wrapped successor index.
   always_comb begin
      w_active_ext = {1'b0, bus.active_neuron};
      w_n_sel      = (w_active_ext < LP_NUM) ? w_active_ext : LP_NUM;
      w_start_idx  = ({1'b0, r_rr_ptr} < w_n_sel) ? r_rr_ptr : '0;
      w_lane       = bus.spike_vec[int'(r_idx)*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
      w_n_last     = r_n - 1'b1;
      w_last_lane  = (r_cnt == w_n_last);
      w_idx_inc    = ({1'b0, r_idx} == w_n_last) ? '0 : r_idx + 1'b1;
   end

   // Next-state and datapath decisions. Abort has priority over lane processing.
   always_comb begin
      w_state_nxt       = r_state;
      w_idx_nxt         = r_idx;
      w_cnt_nxt         = r_cnt;
      w_n_nxt           = r_n;
      w_rr_ptr_nxt      = r_rr_ptr;
      w_spike_in_nxt    = r_spike_in;
      w_spike_count_nxt = r_spike_count;
      w_err_nxt         = r_err;
      case (r_state)
         S_IDLE: begin
            if (bus.en_network) begin
               w_state_nxt = S_SCAN;
               w_idx_nxt   = w_start_idx;
               w_cnt_nxt   = '0;
               w_n_nxt     = w_n_sel;
            end
         end
         S_SCAN: begin
            if (!bus.en_network) begin
               w_state_nxt = S_IDLE;
            end else if (r_n == '0) begin
               w_spike_in_nxt = '0;
               w_state_nxt    = S_DONE;
            end else if ((w_lane == 2'd1) || (w_lane == 2'd2)) begin
               w_spike_in_nxt = {w_lane, r_idx};
               w_rr_ptr_nxt   = w_idx_inc;
               if (r_spike_count != {CNT_WIDTH{1'b1}}) begin
                  w_spike_count_nxt = r_spike_count + 1'b1;
               end
               w_state_nxt = S_DONE;
            end else begin
               if (w_lane == 2'd3) begin
                  w_err_nxt = 1'b1;
               end
               if (w_last_lane) begin
                  w_spike_in_nxt = '0;
                  w_state_nxt    = S_DONE;
               end else begin
                  w_idx_nxt = w_idx_inc;
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (!bus.en_network) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset clears everything immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_n           <= '0;
         r_rr_ptr      <= '0;
         r_spike_in    <= '0;
         r_spike_count <= '0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_idx         <= w_idx_nxt;
         r_cnt         <= w_cnt_nxt;
         r_n           <= w_n_nxt;
         r_rr_ptr      <= w_rr_ptr_nxt;
         r_spike_in    <= w_spike_in_nxt;
         r_spike_count <= w_spike_count_nxt;
         r_err         <= w_err_nxt;
      end
   end

   assign bus.spike_in    = r_spike_in;
   assign bus.networkDone = (r_state == S_DONE);
   assign bus.spike_count = r_spike_count;
   assign bus.err_illegal = r_err;
   assign bus.dbg_state   = r_state;
   assign bus.dbg_rr_ptr  = r_rr_ptr;
endmodule
